race_timer: RTL and testbench

Parametrised game timer and race-statistics unit for the typing-race datapath. Runs on the divided tick clock `clk_div` (one tick = 1/TICK_HZ s) and counts elapsed and remaining time, completed words, typed and correct characters. It derives progress percent, WPM and accuracy, and raises `finish` in both time-limited and word-limited modes. It generalises the per-race counters with configurable tick rate, time cap and word-target widths, an explicit run FSM, and optional pause.

---
 rtl/race_timer.sv | 169 ++++++++++++++++
 tb/tb_race_timer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/race_timer.sv
// race_timer: tick-domain race clock, word counters and derived WPM/accuracy/progress.
// Define RACE_TIMER_PAUSE_EN to honour pause_i and enable the PAUSED state.
module race_timer #(
  parameter  int TICK_HZ   = 100,
  parameter  int MAX_TICKS = 18000,
  parameter  int VALUE_W   = 7,
  parameter  int CHAR_W    = 5,
  parameter  int STAT_W    = 11,
  localparam int EW        = $clog2(MAX_TICKS+1),
  localparam int RW        = VALUE_W+$clog2(TICK_HZ)+1
) (
  input  logic              clk_div,
  input  logic              rst,
  input  logic [1:0]        state_i,
  input  logic              mode_i,
  input  logic [VALUE_W-1:0] value_i,
  input  logic              word_done_i,
  input  logic [CHAR_W-1:0] word_typed_i,
  input  logic [CHAR_W-1:0] word_correct_i,
  input  logic              pause_i,
  output logic [EW-1:0]     elapsed_o,
  output logic [RW-1:0]     remaining_o,
  output logic [STAT_W-1:0] words_o,
  output logic [6:0]        percent_o,
  output logic [9:0]        wpm_o,
  output logic [6:0]        acc_o,
  output logic              finish_o
);

  localparam int PW0 = STAT_W+$clog2(60*TICK_HZ)+1;
  localparam int PW1 = (RW+8 > PW0) ? RW+8 : PW0;
  localparam int PW  = (EW+4 > PW1) ? EW+4 : PW1;
  localparam logic [1:0] ST_SELECT = 2'd0;
  localparam logic [1:0] ST_INGAME = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [EW-1:0]     elapsed_q, elapsed_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [STAT_W-1:0] words_q, words_d;
  logic [STAT_W-1:0] typed_q, typed_d;
  logic [STAT_W-1:0] corr_q, corr_d;
  logic [6:0]        pct_q, pct_d;
  logic [9:0]        wpm_q, wpm_d;
  logic [6:0]        acc_q, acc_d;
  logic [PW-1:0]     pq, aq, wq;
  logic [RW-1:0]     tot_w;
  logic              sel_w, fin_w, pause_w;

`ifdef RACE_TIMER_PAUSE_EN
  assign pause_w = pause_i;
`else
  logic pause_unused;
  assign pause_unused = pause_i;
  assign pause_w      = 1'b0;
`endif

  function automatic logic [STAT_W-1:0] sat_add(
    input logic [STAT_W-1:0] a,
    input logic [STAT_W-1:0] b
  );
    logic [STAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

  assign tot_w = RW'(value_i) * RW'(TICK_HZ);
  assign sel_w = (state_i == ST_SELECT);
  assign fin_w = (fsm_q == RUN) &&
                 ((elapsed_q == EW'(MAX_TICKS)) ||
                  (!mode_i && rem_q == '0) ||
                  (mode_i && PW'(words_q) >= PW'(value_i)));

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (state_i == ST_INGAME) fsm_d = RUN;
      RUN:     if (fin_w) fsm_d = DONE;
               else if (pause_w) fsm_d = PAUSED;
      PAUSED:  if (!pause_w) fsm_d = RUN;
      DONE:    fsm_d = DONE;
      default: fsm_d = IDLE;
    endcase
    if (sel_w) fsm_d = IDLE;
  end

  always_comb begin
    elapsed_d = elapsed_q;
    rem_d     = rem_q;
    words_d   = words_q;
    typed_d   = typed_q;
    corr_d    = corr_q;
    if (fsm_q == IDLE && sel_w) begin
      rem_d     = tot_w;
      elapsed_d = '0;
      words_d   = '0;
      typed_d   = '0;
      corr_d    = '0;
    end else begin
      if (fsm_q == RUN) begin
        if (elapsed_q < EW'(MAX_TICKS)) elapsed_d = elapsed_q + 1'b1;
        if (!mode_i && rem_q != '0) rem_d = rem_q - 1'b1;
      end
      // Words committed during a pause still count toward the totals.
      if (word_done_i && (fsm_q == RUN || fsm_q == PAUSED)) begin
        words_d = sat_add(words_q, STAT_W'(1));
        typed_d = sat_add(typed_q, STAT_W'(word_typed_i));
        corr_d  = sat_add(corr_q, STAT_W'(word_correct_i));
      end
    end
  end

  always_comb begin
    pq    = '0;
    pct_d = '0;
    if (value_i != '0) begin
      if (!mode_i) begin
        if (rem_q <= tot_w) pq = (PW'(tot_w - rem_q) * PW'(100)) / PW'(tot_w);
      end else begin
        pq = (PW'(words_q) * PW'(100)) / PW'(value_i);
      end
    end
    pct_d = (pq > PW'(100)) ? 7'd100 : 7'(pq);
  end

  always_comb begin
    aq    = '0;
    wq    = '0;
    if (typed_q != '0) aq = (PW'(corr_q) * PW'(100)) / PW'(typed_q);
    if (elapsed_q != '0)
      wq = (PW'(corr_q) * PW'(60*TICK_HZ)) / (PW'(elapsed_q) * PW'(5));
    acc_d = (aq > PW'(100)) ? 7'd100 : 7'(aq);
    wpm_d = (wq > PW'(999)) ? 10'd999 : 10'(wq);
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      fsm_q     <= IDLE;
      elapsed_q <= '0;
      rem_q     <= '0;
      words_q   <= '0;
      typed_q   <= '0;
      corr_q    <= '0;
      pct_q     <= '0;
      wpm_q     <= '0;
      acc_q     <= '0;
    end else begin
      fsm_q     <= fsm_d;
      elapsed_q <= elapsed_d;
      rem_q     <= rem_d;
      words_q   <= words_d;
      typed_q   <= typed_d;
      corr_q    <= corr_d;
      pct_q     <= pct_d;
      wpm_q     <= wpm_d;
      acc_q     <= acc_d;
    end
  end

  assign elapsed_o   = elapsed_q;
  assign remaining_o = rem_q;
  assign words_o     = words_q;
  assign percent_o   = pct_q;
  assign wpm_o       = wpm_q;
  assign acc_o       = acc_q;
  assign finish_o    = (fsm_q == DONE);

endmodule

// File: tb/tb_race_timer.sv
// tb_race_timer: randomized races against a behavioural race model,
// expected outputs queued per tick and checked by an independent monitor.
module tb_race_timer;

  localparam int HZ   = 100;
  localparam int MAXT = 18000;
  localparam int SMAX = 2047;
`ifdef RACE_TIMER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic        clk_div = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  state = 2'd0;
  logic        mode = 1'b0;
  logic [6:0]  value = 7'd0;
  logic        word_done = 1'b0;
  logic [4:0]  word_typed = 5'd0;
  logic [4:0]  word_correct = 5'd0;
  logic        pause = 1'b0;
  logic [14:0] elapsed;
  logic [14:0] remaining;
  logic [10:0] words;
  logic [6:0]  percent;
  logic [9:0]  wpm;
  logic [6:0]  acc;
  logic        finish;

  race_timer dut (
    .clk_div       (clk_div),
    .rst           (rst),
    .state_i       (state),
    .mode_i        (mode),
    .value_i       (value),
    .word_done_i   (word_done),
    .word_typed_i  (word_typed),
    .word_correct_i(word_correct),
    .pause_i       (pause),
    .elapsed_o     (elapsed),
    .remaining_o   (remaining),
    .words_o       (words),
    .percent_o     (percent),
    .wpm_o         (wpm),
    .acc_o         (acc),
    .finish_o      (finish)
  );

  always #5 clk_div = ~clk_div;

  typedef struct {
    int el, rem, wds, pct, wpm, acc, fin;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // race model: the race is waiting, ticking, held, or over
  bit m_ticking, m_held, m_over;
  int m_el, m_rem, m_wds, m_typ, m_cor;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, req);
    end
  endfunction

  function automatic void model_clear();
    m_ticking = 0; m_held = 0; m_over = 0;
    m_el = 0; m_rem = 0; m_wds = 0; m_typ = 0; m_cor = 0;
  endfunction

  function automatic exp_t model_step(input int st, input bit md,
      input int val, input bit wd, input int wt, input int wc, input bit pz);
    exp_t e;
    int tot;
    bit done_now;
    tot = val * HZ;
    e.pct = 0;
    if (val != 0) begin
      if (!md) e.pct = (m_rem > tot) ? 0 : (tot - m_rem) * 100 / tot;
      else     e.pct = imin(m_wds * 100 / val, 100);
    end
    e.acc = (m_typ == 0) ? 0 : imin(m_cor * 100 / m_typ, 100);
    e.wpm = (m_el == 0) ? 0 : imin(m_cor * 60 * HZ / (5 * m_el), 999);
    done_now = m_ticking && !m_held &&
               (m_el == MAXT || (!md && m_rem == 0) || (md && m_wds >= val));
    if (!m_ticking && !m_over && st == 0) begin
      m_rem = tot; m_el = 0; m_wds = 0; m_typ = 0; m_cor = 0;
    end else begin
      if (m_ticking && !m_held) begin
        m_el = imin(m_el + 1, MAXT);
        if (!md && m_rem > 0) m_rem--;
      end
      if (wd && m_ticking) begin
        m_wds = imin(m_wds + 1, SMAX);
        m_typ = imin(m_typ + wt, SMAX);
        m_cor = imin(m_cor + wc, SMAX);
      end
    end
    if (st == 0) begin
      m_ticking = 0; m_held = 0; m_over = 0;
    end else if (!m_ticking && !m_over) begin
      if (st == 2) m_ticking = 1;
    end else if (m_ticking && !m_held) begin
      if (done_now) begin m_ticking = 0; m_over = 1; end
      else if (PAUSE_EN && pz) m_held = 1;
    end else if (m_held && !pz) begin
      m_held = 0;
    end
    e.el = m_el; e.rem = m_rem; e.wds = m_wds; e.fin = m_over;
    return e;
  endfunction

  task automatic tick(input int st, input bit md, input int val,
      input bit wd, input int wt, input int wc, input bit pz);
    @(negedge clk_div);
    rst = 1'b0;
    state = 2'(st); mode = md; value = 7'(val);
    word_done = wd; word_typed = 5'(wt); word_correct = 5'(wc); pause = pz;
    sb.push_back(model_step(st, md, val, wd, wt, wc, pz));
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_elapsed"}, int'(elapsed), 0);
    chk({tag, "_remaining"}, int'(remaining), 0);
    chk({tag, "_words"}, int'(words), 0);
    chk({tag, "_percent"}, int'(percent), 0);
    chk({tag, "_wpm"}, int'(wpm), 0);
    chk({tag, "_acc"}, int'(acc), 0);
    chk({tag, "_finish"}, int'(finish), 0);
  endtask

  task automatic do_reset();
    exp_t z;
    @(negedge clk_div);
    rst = 1'b1;
    model_clear();
    z = '{0, 0, 0, 0, 0, 0, 0};
    sb.push_back(z);
    #1;
    zero_check("async_rst");
  endtask

  task automatic race(input bit md, input int val, input int ncyc,
      input int rate, input int pz_at, input int pz_len);
    int wt;
    bit wd, pz;
    for (int i = 0; i < 3; i++) tick(0, md, val, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) tick(1, md, val, 0, 0, 0, 0);
    for (int i = 0; i < ncyc; i++) begin
      wd = ($urandom_range(0, 999) < rate);
      wt = $urandom_range(1, 31);
      pz = (i >= pz_at) && (i < pz_at + pz_len);
      tick(2, md, val, wd, wt, $urandom_range(0, wt), pz);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_div);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("elapsed", int'(elapsed), e.el);
        chk("remaining", int'(remaining), e.rem);
        chk("words", int'(words), e.wds);
        chk("percent", int'(percent), e.pct);
        chk("wpm", int'(wpm), e.wpm);
        chk("acc", int'(acc), e.acc);
        chk("finish", int'(finish), e.fin);
      end
    end
  end

  initial begin : driver
    model_clear();
    #2;
    zero_check("reset");
    // time mode 15 s: 1500 ticks then finish, percent 100
    race(0, 15, 1510, 50, 100000, 0);
    // word mode 10 words, extra pulses after finish are ignored
    race(1, 10, 200, 200, 100000, 0);
    // accuracy 6/8 = 75
    for (int i = 0; i < 2; i++) tick(0, 1, 20, 0, 0, 0, 0);
    tick(2, 1, 20, 0, 0, 0, 0);
    tick(2, 1, 20, 1, 3, 3, 0);
    tick(2, 1, 20, 1, 3, 2, 0);
    tick(2, 1, 20, 1, 2, 1, 0);
    for (int i = 0; i < 4; i++) tick(2, 1, 20, 0, 0, 0, 0);
    // pause window of 200 ticks mid-race
    race(0, 30, 600, 30, 100, 200);
    // word mode never completed: tick cap ends it
    race(1, 127, 18010, 2, 100000, 0);
    // reset mid-race, then a fresh race
    race(0, 20, 300, 50, 100000, 0);
    do_reset();
    race(0, 3, 320, 80, 50, 40);
    // value 0 and random races
    race(0, 0, 20, 50, 100000, 0);
    for (int r = 0; r < 6; r++)
      race(1'($urandom_range(0, 1)), $urandom_range(0, 8),
           $urandom_range(100, 1000), $urandom_range(0, 300),
           $urandom_range(0, 300), $urandom_range(0, 100));
    for (int i = 0; i < 3; i++) tick(0, 0, 5, 0, 0, 0, 0);
    @(posedge clk_div);
    #3;
    chk("queue_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
